uart_tx: RTL and testbench

UART transmitter that serialises bytes produced by the command decoder onto the board TX pin. It consumes the decoder's `snd_data`/`snd_ready` and returns `snd_busy`, closing the decode → notify loop back to the host. It sends 8 data bits LSB-first, with optional parity and one stop bit, at a baud rate set by parameters. One frame is in flight at a time; there is no internal FIFO.

---
 rtl/uart_tx_if.sv | 14 +
 rtl/uart_tx.sv | 145 ++++++++++++++
 tb/tb_uart_tx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// uart_tx_if: producer-side send handshake and serial line for uart_tx.
`default_nettype none

interface uart_tx_if;
  logic [7:0] snd_data;
  logic       snd_ready;
  logic       snd_busy;
  logic       tx;

  modport master (output snd_data, output snd_ready, input snd_busy, input tx);
  modport slave  (input snd_data, input snd_ready, output snd_busy, output tx);
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 / 8E1 / 8O1 UART transmitter, one frame in flight, no FIFO.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  uart_tx_if.slave   bus
);

  localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int          CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] C_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic        C_ODD        = (PARITY == 2);
  localparam logic        C_HAS_PAR    = (PARITY != 0);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx: CLK_FREQ / BAUD must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt,   w_cnt;
  logic [2:0]      r_idx,   w_idx;
  logic [7:0]      r_shift, w_shift;
  logic            r_par,   w_par;
  logic            r_tx,    w_tx;
  logic            r_busy,  w_busy;
  logic            w_bit_end;

  assign w_bit_end    = (r_cnt == C_CNT_MAX);
  assign bus.tx       = r_tx;
  assign bus.snd_busy = r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
    end
  end

  // Next-state logic also produces the next output values, so tx/busy are registered.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_par   = r_par;
    w_tx    = r_tx;
    w_busy  = r_busy;

    if (r_state != S_IDLE) begin
      w_cnt = w_bit_end ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (bus.snd_ready) begin
          w_shift = bus.snd_data;
          w_par   = (^bus.snd_data) ^ C_ODD;
          w_tx    = 1'b0;
          w_busy  = 1'b1;
          w_cnt   = '0;
          w_state = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_idx   = 3'd0;
          w_tx    = r_shift[0];
          w_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == 3'd7) begin
            if (C_HAS_PAR) begin
              w_tx    = r_par;
              w_state = S_PARITY;
            end else begin
              w_tx    = 1'b1;
              w_state = S_STOP;
            end
          end else begin
            w_idx = r_idx + 3'd1;
            w_tx  = r_shift[r_idx + 3'd1];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_tx    = 1'b1;
          w_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_tx    = 1'b1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench, three DUTs for PARITY = 0/1/2 at 10 clocks per bit.
`default_nettype none

module tb_uart_tx;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();

  uart_tx #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(0)) u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  uart_tx #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  uart_tx #(.CLK_FREQ(1000000), .BAUD(100000), .PARITY(2)) u_dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  logic tx_s   [3];
  logic busy_s [3];
  assign tx_s[0] = if0.tx;  assign busy_s[0] = if0.snd_busy;
  assign tx_s[1] = if1.tx;  assign busy_s[1] = if1.snd_busy;
  assign tx_s[2] = if2.tx;  assign busy_s[2] = if2.snd_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic rdy, input logic [7:0] d);
    case (sel)
      0: begin if0.snd_ready = rdy; if0.snd_data = d; end
      1: begin if1.snd_ready = rdy; if1.snd_data = d; end
      default: begin if2.snd_ready = rdy; if2.snd_data = d; end
    endcase
  endtask

  // Called just after the accept edge; samples each bit at its centre until busy drops.
  task automatic capture(input int sel, output logic [10:0] bits, output int len);
    int s;
    s    = 0;
    bits = '1;
    while (busy_s[sel] && s < 300) begin
      if ((s % 10) == 5 && (s / 10) < 11) bits[s / 10] = tx_s[sel];
      s++;
      tick();
    end
    len = s;
  endtask

  task automatic send(input int sel, input logic [7:0] d, output logic [10:0] bits, output int len);
    drive(sel, 1'b1, d);
    tick();
    drive(sel, 1'b0, 8'h00);
    capture(sel, bits, len);
  endtask

  logic [10:0] bits;
  int          len;

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(0, 1'b1, 8'h00);
    drive(1, 1'b0, 8'h00);
    drive(2, 1'b0, 8'h00);
    reset_n = 1'b0;

    // Reset held with a pending request.
    repeat (3) tick();
    check("rst_tx",   tx_s[0],   1'b1);
    check("rst_busy", busy_s[0], 1'b0);
    #2 reset_n = 1'b1;
    tick();
    check("post_rst_busy", busy_s[0], 1'b1);
    check("post_rst_tx",   tx_s[0],   1'b0);
    drive(0, 1'b0, 8'h00);
    capture(0, bits, len);
    check("f00_bits", bits[9:0], {1'b1, 8'h00, 1'b0});
    check("f00_len",  len, 100);
    tick();

    // 0xA5, no parity; outputs must not change before the accept edge.
    drive(0, 1'b1, 8'hA5);
    #1;
    check("a5_pre_tx",   tx_s[0],   1'b1);
    check("a5_pre_busy", busy_s[0], 1'b0);
    tick();
    drive(0, 1'b0, 8'h00);
    capture(0, bits, len);
    check("a5_bits", bits[9:0], 10'b1_1010_0101_0);
    check("a5_len",  len, 100);

    // 0x03 with even and odd parity.
    send(1, 8'h03, bits, len);
    check("p_even_bits", bits, {1'b1, 1'b0, 8'h03, 1'b0});
    check("p_even_len",  len, 110);
    send(2, 8'h03, bits, len);
    check("p_odd_bits", bits, {1'b1, 1'b1, 8'h03, 1'b0});
    check("p_odd_len",  len, 110);

    // Back-to-back with snd_ready held high.
    drive(0, 1'b1, 8'h55);
    tick();
    drive(0, 1'b1, 8'h3C);
    capture(0, bits, len);
    check("b2b1_bits", bits[9:0], {1'b1, 8'h55, 1'b0});
    check("b2b1_len",  len, 100);
    check("b2b_gap_busy", busy_s[0], 1'b0);
    drive(0, 1'b1, 8'hFF);
    tick();
    drive(0, 1'b0, 8'h00);
    check("b2b2_start_busy", busy_s[0], 1'b1);
    capture(0, bits, len);
    check("b2b2_bits", bits[9:0], {1'b1, 8'hFF, 1'b0});
    check("b2b2_len",  len, 100);
    tick();

    // Asynchronous reset partway through a 0x81 frame.
    drive(0, 1'b1, 8'h81);
    tick();
    drive(0, 1'b0, 8'h00);
    repeat (45) tick();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_tx",   tx_s[0],   1'b1);
    check("mid_rst_busy", busy_s[0], 1'b0);
    tick();
    #2 reset_n = 1'b1;
    tick();
    send(0, 8'h81, bits, len);
    check("f81_bits", bits[9:0], {1'b1, 8'h81, 1'b0});
    check("f81_len",  len, 100);
    tick();

    // Reply byte recovered from the line by centre sampling.
    send(0, 8'h04, bits, len);
    check("rx_04", bits[8:1], 8'h04);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
